sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the fixed 8-bit/16-deep synchronous FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow flags with explicit clear. It sits between any two same-clock producer/consumer blocks and is the standard buffering primitive for new datapaths.

---
 rtl/sync_fifo_param.sv | 124 ++++++++++++
 tb/tb_sync_fifo_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// registered read data with valid strobe, and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           WRITE_DATA,
    input  logic                       rd,
    input  logic                       ERR_CLR,
    output logic [WIDTH-1:0]           READ_DATA,
    output logic                       RD_VALID,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       ALMOST_FULL,
    output logic                       ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [AW-1:0]    ptr_t;
    typedef logic [CW-1:0]    cnt_t;
    typedef logic [WIDTH-1:0] word_t;

    localparam ptr_t PtrOne   = ptr_t'(1);
    localparam cnt_t CntOne   = cnt_t'(1);
    localparam cnt_t DepthCnt = cnt_t'(DEPTH);
    localparam cnt_t AfCnt    = cnt_t'(AF_LEVEL);
    localparam cnt_t AeCnt    = cnt_t'(AE_LEVEL);

    word_t mem [DEPTH];

    ptr_t  wptr_q, wptr_d;
    ptr_t  rptr_q, rptr_d;
    cnt_t  count_q, count_d;
    word_t rdata_q, rdata_d;
    logic  rvalid_q, rvalid_d;
    logic  ovf_q, ovf_d;
    logic  udf_q, udf_d;

    logic  full, empty;
    logic  rd_ok, wr_ok;

    // Status decodes from the registered count only, so flags move with COUNT.
    always_comb begin
        full  = (count_q == DepthCnt);
        empty = (count_q == '0);
        rd_ok = rd & ~empty;
        wr_ok = wr & (~full | rd_ok);
    end

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        if (wr_ok) begin
            wptr_d = wptr_q + PtrOne;
        end
        if (rd_ok) begin
            rptr_d   = rptr_q + PtrOne;
            rdata_d  = mem[rptr_q];
            rvalid_d = 1'b1;
        end

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d = (wr & ~wr_ok) | (ovf_q & ~ERR_CLR);
        udf_d = (rd & empty)  | (udf_q & ~ERR_CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is intentionally not reset; equal pointers make it logically empty.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wptr_q] <= WRITE_DATA;
        end
    end

    assign READ_DATA    = rdata_q;
    assign RD_VALID     = rvalid_q;
    assign COUNT        = count_q;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (count_q >= AfCnt);
    assign ALMOST_EMPTY = (count_q <= AeCnt);
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at WIDTH=8, DEPTH=16, AF=12, AE=3.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic       err_clr;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full, empty, afull, aempty;
    logic [4:0] count;
    logic       ovf, udf;

    int compared   = 0;
    int mismatched = 0;

    sync_fifo_param #(
        .WIDTH   (8),
        .DEPTH   (16),
        .AF_LEVEL(12),
        .AE_LEVEL(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr),
        .WRITE_DATA  (wdata),
        .rd          (rd),
        .ERR_CLR     (err_clr),
        .READ_DATA   (rdata),
        .RD_VALID    (rvalid),
        .FULL        (full),
        .EMPTY       (empty),
        .ALMOST_FULL (afull),
        .ALMOST_EMPTY(aempty),
        .COUNT       (count),
        .OVERFLOW    (ovf),
        .UNDERFLOW   (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " READ_DATA"}, 32'(rdata), 32'h0);
        check({tag, " RD_VALID"}, 32'(rvalid), 32'h0);
        check({tag, " COUNT"}, 32'(count), 32'h0);
        check({tag, " EMPTY"}, 32'(empty), 32'h1);
        check({tag, " FULL"}, 32'(full), 32'h0);
        check({tag, " ALMOST_FULL"}, 32'(afull), 32'h0);
        check({tag, " ALMOST_EMPTY"}, 32'(aempty), 32'h1);
        check({tag, " OVERFLOW"}, 32'(ovf), 32'h0);
        check({tag, " UNDERFLOW"}, 32'(udf), 32'h0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_word;
        int         cnt;
        int         sent;
        int         got;
        int         cyc;
        logic       m_rd_ok, m_wr_ok;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; wdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("init");

        // Fill 0x01..0x11; the 17th write is dropped.
        for (int i = 1; i <= 17; i++) begin
            wr = 1'b1; wdata = 8'(i);
            tick();
            cnt = (i < 16) ? i : 16;
            check($sformatf("fill%0d COUNT", i), 32'(count), 32'(cnt));
            check($sformatf("fill%0d FULL", i), 32'(full), 32'(cnt == 16));
            check($sformatf("fill%0d AF", i), 32'(afull), 32'(cnt >= 12));
            check($sformatf("fill%0d AE", i), 32'(aempty), 32'(cnt <= 3));
            check($sformatf("fill%0d OVF", i), 32'(ovf), 32'(i == 17));
        end
        wr = 1'b0;

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr OVF", 32'(ovf), 32'h0);
        check("clr COUNT", 32'(count), 32'd16);

        // Simultaneous read/write while full.
        wr = 1'b1; rd = 1'b1; wdata = 8'hAA;
        tick();
        wr = 1'b0;
        check("fullrw COUNT", 32'(count), 32'd16);
        check("fullrw OVF", 32'(ovf), 32'h0);
        check("fullrw READ_DATA", 32'(rdata), 32'h01);
        check("fullrw RD_VALID", 32'(rvalid), 32'h1);

        // Drain: 0x02..0x10 then 0xAA, then one underflowing read.
        for (int j = 1; j <= 16; j++) begin
            tick();
            cnt = 16 - j;
            exp_word = (j < 16) ? 8'(j + 1) : 8'hAA;
            check($sformatf("drain%0d READ_DATA", j), 32'(rdata), 32'(exp_word));
            check($sformatf("drain%0d RD_VALID", j), 32'(rvalid), 32'h1);
            check($sformatf("drain%0d COUNT", j), 32'(count), 32'(cnt));
            check($sformatf("drain%0d EMPTY", j), 32'(empty), 32'(cnt == 0));
            check($sformatf("drain%0d AF", j), 32'(afull), 32'(cnt >= 12));
            check($sformatf("drain%0d AE", j), 32'(aempty), 32'(cnt <= 3));
        end
        tick();
        rd = 1'b0;
        check("udf UNDERFLOW", 32'(udf), 32'h1);
        check("udf RD_VALID", 32'(rvalid), 32'h0);
        check("udf READ_DATA", 32'(rdata), 32'hAA);
        check("udf COUNT", 32'(count), 32'h0);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr UDF", 32'(udf), 32'h0);

        // Simultaneous read/write while empty: write lands, read rejected.
        wr = 1'b1; rd = 1'b1; wdata = 8'h55;
        tick();
        wr = 1'b0; rd = 1'b0;
        check("emptyrw COUNT", 32'(count), 32'd1);
        check("emptyrw UDF", 32'(udf), 32'h1);
        check("emptyrw RD_VALID", 32'(rvalid), 32'h0);
        check("emptyrw EMPTY", 32'(empty), 32'h0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("emptyrw READ_DATA", 32'(rdata), 32'h55);
        check("emptyrw RD_VALID2", 32'(rvalid), 32'h1);
        check("emptyrw COUNT2", 32'(count), 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Stream 40 words across pointer wrap against a queue model.
        q.delete();
        cnt = 0; sent = 0; got = 0; cyc = 0;
        while ((sent < 40 || got < 40) && cyc < 300) begin
            wr = (sent < 40) && ((cyc % 4) != 3);
            rd = ((cyc % 2) == 1) || (sent >= 40);
            wdata = 8'(8'hC0 + sent);
            m_rd_ok = rd && (cnt > 0);
            m_wr_ok = wr && ((cnt < 16) || m_rd_ok);
            exp_word = 8'h00;
            if (m_rd_ok) exp_word = q.pop_front();
            if (m_wr_ok) begin
                q.push_back(wdata);
                sent++;
            end
            cnt = cnt + int'(m_wr_ok) - int'(m_rd_ok);
            tick();
            check($sformatf("stream%0d COUNT", cyc), 32'(count), 32'(cnt));
            check($sformatf("stream%0d RD_VALID", cyc), 32'(rvalid), 32'(m_rd_ok));
            if (m_rd_ok) begin
                check($sformatf("stream%0d READ_DATA", cyc), 32'(rdata), 32'(exp_word));
                got++;
            end
            cyc++;
        end
        wr = 1'b0; rd = 1'b0;
        check("stream complete", 32'(got), 32'd40);
        check("stream OVF", 32'(ovf), 32'h0);

        // Refill, then overflow in the same cycle as ERR_CLR.
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; wdata = 8'(8'h80 + i);
            tick();
        end
        check("refill FULL", 32'(full), 32'h1);
        err_clr = 1'b1; wdata = 8'hEE;
        tick();
        wr = 1'b0;
        check("clr+ovf OVF", 32'(ovf), 32'h1);
        tick();
        err_clr = 1'b0;
        check("clr only OVF", 32'(ovf), 32'h0);

        // Set OVERFLOW and a live read, then reset mid-traffic.
        wr = 1'b1;
        tick();
        check("pre-rst OVF", 32'(ovf), 32'h1);
        rd = 1'b1; wdata = 8'h99;
        tick();
        check("pre-rst READ_DATA", 32'(rdata), 32'h80);
        check("pre-rst RD_VALID", 32'(rvalid), 32'h1);
        rst = 1'b1;
        tick();
        check_reset_state("midrst");
        tick();
        rst = 1'b0; rd = 1'b0; wdata = 8'h77;
        tick();
        wr = 1'b0;
        check("postrst COUNT", 32'(count), 32'd1);
        check("postrst EMPTY", 32'(empty), 32'h0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("postrst READ_DATA", 32'(rdata), 32'h77);
        check("postrst RD_VALID", 32'(rvalid), 32'h1);
        check("postrst UDF", 32'(udf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
